// File: rtl/led_arbiter_if.sv
// Request/status bundle between LED arbiter clients and the arbiter itself.
// master drives heartbeat/error/activity requests; slave is the arbiter that returns the LED drive.
interface led_arbiter_if;
   logic       i_heartbeat;
   logic       i_err_req;
   logic [3:0] i_err_code;
   logic       i_activity;
   logic       o_led;
   logic [1:0] o_owner;
   logic       o_err_busy;

   modport master (
      output i_heartbeat, i_err_req, i_err_code, i_activity,
      input  o_led, o_owner, o_err_busy
   );

   modport slave (
      input  i_heartbeat, i_err_req, i_err_code, i_activity,
      output o_led, o_owner, o_err_busy
   );
endinterface

// File: rtl/led_arbiter.sv
// LED arbiter: error blink codes > activity flash > heartbeat, all outputs registered (1-cycle latency).
// Activity window is built only when LED_ARB_ACT_EN is defined; otherwise i_activity is ignored.
module led_arbiter #(
   parameter int unsigned CLK_HZ   = 12_000_000,
   parameter int unsigned PULSE_MS = 200,
   parameter int unsigned GAP_MS   = 1000,
   parameter int unsigned ACT_MS   = 50
) (
   input  logic         clock,
   input  logic         reset,
   led_arbiter_if.slave bus
);

   localparam logic [31:0] PULSE_CYC = 32'(CLK_HZ / 32'd1000 * PULSE_MS);
   localparam logic [31:0] GAP_CYC   = 32'(CLK_HZ / 32'd1000 * GAP_MS);
   localparam logic [31:0] ACT_CYC   = 32'(CLK_HZ / 32'd1000 * ACT_MS);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ON   = 2'd1;
   localparam logic [1:0] ST_OFF  = 2'd2;
   localparam logic [1:0] ST_GAP  = 2'd3;

   localparam logic [1:0] OWN_HB  = 2'b00;
   localparam logic [1:0] OWN_ACT = 2'b01;
   localparam logic [1:0] OWN_ERR = 2'b10;

   logic [1:0]  state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [3:0]  pulse_q, pulse_d;
   logic        led_q, led_d;
   logic [1:0]  owner_q, owner_d;
   logic        busy_q, busy_d;

   logic        cnt_last;
   logic [3:0]  code_sat;
   logic        act_win;

   assign code_sat = (bus.i_err_code == 4'd0) ? 4'd1 : bus.i_err_code;
   // <=1 rather than ==1 so a zero-length phase still advances
   assign cnt_last = (cnt_q <= 32'd1);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pulse_d = pulse_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.i_err_req) begin
               state_d = ST_ON;
               cnt_d   = PULSE_CYC;
               pulse_d = code_sat;
            end
         end
         ST_ON: begin
            if (!cnt_last) begin
               cnt_d = cnt_q - 32'd1;
            end else if (pulse_q > 4'd1) begin
               state_d = ST_OFF;
               cnt_d   = PULSE_CYC;
            end else begin
               state_d = ST_GAP;
               cnt_d   = GAP_CYC;
            end
         end
         ST_OFF: begin
            if (!cnt_last) begin
               cnt_d = cnt_q - 32'd1;
            end else begin
               state_d = ST_ON;
               cnt_d   = PULSE_CYC;
               pulse_d = pulse_q - 4'd1;
            end
         end
         ST_GAP: begin
            if (!cnt_last) begin
               cnt_d = cnt_q - 32'd1;
            end else if (bus.i_err_req) begin
               state_d = ST_ON;
               cnt_d   = PULSE_CYC;
               pulse_d = code_sat;
            end else begin
               state_d = ST_IDLE;
               cnt_d   = 32'd0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 32'd0;
            pulse_d = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= 32'd0;
         pulse_q <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pulse_q <= pulse_d;
      end
   end

`ifdef LED_ARB_ACT_EN
   logic        act_prev_q;
   logic [31:0] act_cnt_q, act_cnt_d;
   logic        act_rise;

   assign act_rise = bus.i_activity & ~act_prev_q;

   // Keeps counting while error owns the LED, so the window can lapse unseen
   always_comb begin
      act_cnt_d = act_cnt_q;
      if (act_rise) begin
         act_cnt_d = ACT_CYC;
      end else if (act_cnt_q != 32'd0) begin
         act_cnt_d = act_cnt_q - 32'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         act_prev_q <= 1'b0;
         act_cnt_q  <= 32'd0;
      end else begin
         act_prev_q <= bus.i_activity;
         act_cnt_q  <= act_cnt_d;
      end
   end

   assign act_win = (act_cnt_d != 32'd0);
`else
   logic [32:0] unused_act;
   assign unused_act = {bus.i_activity, ACT_CYC};
   assign act_win    = 1'b0;
`endif

   // Output mux works on next state so LED source and owner flip on the same edge
   always_comb begin
      led_d   = bus.i_heartbeat;
      owner_d = OWN_HB;
      if (state_d != ST_IDLE) begin
         led_d   = (state_d == ST_ON);
         owner_d = OWN_ERR;
      end else if (act_win) begin
         led_d   = ~bus.i_heartbeat;
         owner_d = OWN_ACT;
      end
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         led_q   <= 1'b0;
         owner_q <= OWN_HB;
         busy_q  <= 1'b0;
      end else begin
         led_q   <= led_d;
         owner_q <= owner_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.o_led      = led_q;
   assign bus.o_owner    = owner_q;
   assign bus.o_err_busy = busy_q;

   a_busy_owner: assert property (@(posedge clock) busy_q == (owner_q == OWN_ERR));

endmodule

// File: doc/led_arbiter.md
LED_ARBITER -- requirements
Module: led_arbiter

Interface
REQ-001 SHALL have parameter CLK_HZ, default 12_000_000, meaning clock frequency in Hz.
REQ-002 SHALL have parameter PULSE_MS, default 200, meaning error-code pulse ON time and OFF time in ms.
REQ-003 SHALL have parameter GAP_MS, default 1000, meaning dark gap between error-code repetitions in ms.
REQ-004 SHALL have parameter ACT_MS, default 50, meaning activity stretch window in ms.
REQ-005 SHALL have port clock  input  1  single system clock; all logic on posedge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port i_heartbeat  input  1  heartbeat waveform from the heartbeat generator.
REQ-008 SHALL have port i_err_req  input  1  level; high while an error code is to be displayed.
REQ-009 SHALL have port i_err_code  input  4  number of pulses per repetition; 0 treated as 1.
REQ-010 SHALL have port i_activity  input  1  activity strobe, edge-detected (used only when LED_ARB_ACT_EN is defined).
REQ-011 SHALL have port o_led  output  1  registered LED drive.
REQ-012 SHALL have port o_owner  output  2  registered current owner: 00 heartbeat, 01 activity, 10 error, 11 unused.
REQ-013 SHALL have port o_err_busy  output  1  registered; high whenever the error FSM is not IDLE.

Function
REQ-014 SHALL derive cycle counts as CLK_HZ/1000*X_MS (PULSE_CYC, GAP_CYC, ACT_CYC), using 32-bit unsigned arithmetic.
REQ-015 SHALL use fixed priority: error FSM not IDLE > activity window active > heartbeat.
REQ-016 SHALL implement the error FSM with states IDLE, ON, OFF and GAP, using one 32-bit down-counter and a 4-bit pulse counter.
REQ-017 SHALL make the IDLE->ON transition when i_err_req=1, latch max(i_err_code,1) into the pulse counter, and load PULSE_CYC.
REQ-018 SHALL hold ON for PULSE_CYC cycles, then go to OFF if pulses remain, else go to GAP and load GAP_CYC.
REQ-019 SHALL hold OFF for PULSE_CYC cycles, decrement the pulse count, then return to ON.
REQ-020 SHALL, at the end of GAP, go to ON if i_err_req=1 (re-latching i_err_code), else go to IDLE.
REQ-021 SHALL ignore changes of i_err_code or a deassert of i_err_req mid-repetition; the current repetition, including GAP, always completes.
REQ-022 SHALL drive o_led = 1 in ON and 0 in OFF/GAP while error owns, with o_owner = 10.
REQ-023 SHALL, on each rising edge of i_activity, load the activity counter with ACT_CYC; a retrigger inside the window reloads it, and the window is active while the counter is non-zero.
REQ-024 SHALL run the activity counter even while error owns, so that the window may expire unseen.
REQ-025 SHALL, while activity owns, drive o_led = ~i_heartbeat with o_owner = 01.
REQ-026 SHALL, otherwise, drive o_led = i_heartbeat with o_owner = 00.
REQ-027 SHALL register all outputs, so o_led reflects inputs and state with exactly one cycle of latency.
REQ-028 SHALL have o_owner change in the same cycle that o_led switches source, with no glitch cycle.

Reset
REQ-029 SHALL, on reset=1 at a clock edge, force error FSM = IDLE, all counters = 0, edge-detect register = 0, o_led = 0, o_owner = 00 and o_err_busy = 0.
REQ-030 SHALL abort any sequence when reset is asserted mid-sequence, and resume heartbeat pass-through on the first cycle after reset.

Configuration
REQ-031 SHALL, when LED_ARB_ACT_EN is defined, include the activity edge detector, counter and owner 01.
REQ-032 SHALL, when LED_ARB_ACT_EN is undefined, ignore i_activity, never report o_owner = 01, and omit the activity logic.

Verification (CLK_HZ=1000, PULSE_MS=2, GAP_MS=5, ACT_MS=3)
REQ-033 SHALL cover: i_err_req=0, i_activity=0, i_heartbeat toggling -> o_led equals i_heartbeat delayed 1 cycle, o_owner=00.
REQ-034 SHALL cover: i_err_code=3, i_err_req pulsed high 1 cycle -> o_led pattern 1,1,0,0,1,1,0,0,1,1 then 5 zeros, then o_err_busy=0 and o_owner=00.
REQ-035 SHALL cover: i_err_code=0 with i_err_req held -> repeating 2 ON plus 5 GAP cycles (period 7), o_err_busy stays 1.
REQ-036 SHALL cover: i_err_code changed from 2 to 4 during the first ON -> first repetition has 2 pulses, second has 4.
REQ-037 SHALL cover: i_activity pulse, retriggered 2 cycles later -> owner 01 for 5 cycles total with o_led=~i_heartbeat; build without LED_ARB_ACT_EN -> owner stays 00.
REQ-038 SHALL cover: reset asserted during OFF of a code-3 sequence -> next cycle o_led=0, o_owner=00, o_err_busy=0; heartbeat pass-through resumes on the first cycle after reset.
